// File: rtl/tm1638_ctrl.sv
// TM1638 board controller: repeating frame of display-RAM write, brightness/on
// command and key-matrix read over STB/CLK/DIO, with the key vector returned per frame.
module tm1638_ctrl #(
    parameter int unsigned clk_mhz  = 27,
    parameter int unsigned sclk_khz = 500,
    parameter int unsigned w_digit  = 8,
    parameter int unsigned w_led    = 8,
    parameter int unsigned w_key    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [w_digit*8-1:0] seg_data,
    input  logic [w_led-1:0]     led,
    input  logic [2:0]           brightness,
    input  logic                 display_on,
    output logic [w_key-1:0]     key,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 tm_stb,
    output logic                 tm_clk,
    output logic                 tm_dio_out,
    output logic                 tm_dio_oe,
    input  logic                 tm_dio_in
);

    localparam int unsigned HALF_RAW = (clk_mhz * 1000) / (2 * sclk_khz);
    localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int unsigned RDW      = (2 * HALF > clk_mhz) ? 2 * HALF : clk_mhz;
    localparam int unsigned CW       = $clog2(RDW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB_LO,
        S_SHIFT_OUT,
        S_STB_HI,
        S_RD_WAIT,
        S_SHIFT_IN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ph_q, ph_d;
    logic [2:0]          bit_q, bit_d;
    logic [4:0]          byte_q, byte_d;
    logic [1:0]          txn_q, txn_d;
    logic                stb_q, stb_d;
    logic                clk_q, clk_d;
    logic                dout_q, dout_d;
    logic                oe_q, oe_d;

    logic [w_digit*8-1:0] seg_s_q;
    logic [w_led-1:0]     led_s_q;
    logic [2:0]           bri_s_q;
    logic                 don_s_q;

    logic [7:0]          key_acc_q;
    logic [7:0]          key_q;
    logic                rd_done_q;
    logic                kv_q;

    logic                tick;
    logic                snap;
    logic                sample;
    logic                rd_last;
    logic [7:0]          tx_byte;
    logic [4:0]          n_bytes;
    logic [3:0]          addr;
    logic [63:0]         seg_pad;
    logic [7:0]          led_pad;

    // RD_WAIT stretches the counter period to the turnaround length instead of one half
    assign tick = (state_q == S_RD_WAIT) ? (cnt_q == CW'(RDW - 1))
                                         : (cnt_q == CW'(HALF - 1));

    always_comb begin
        seg_pad = 64'(seg_s_q);
        led_pad = 8'(led_s_q);
        addr    = byte_q[3:0] - 4'd1;
        n_bytes = (txn_q == 2'd1) ? 5'd17 : 5'd1;
        tx_byte = 8'h42;
        case (txn_q)
            2'd0: tx_byte = 8'h40;
            2'd1: begin
                if (byte_q == 5'd0) begin
                    tx_byte = 8'hC0;
                end else if (addr[0]) begin
                    tx_byte = {7'b0, led_pad[addr[3:1]]};
                end else begin
                    tx_byte = seg_pad[{addr[3:1], 3'b000} +: 8];
                end
            end
            2'd2: tx_byte = {4'b1000, don_s_q, bri_s_q};
            default: tx_byte = 8'h42;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        txn_d   = txn_q;
        stb_d   = stb_q;
        clk_d   = clk_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        snap    = 1'b0;
        sample  = 1'b0;
        rd_last = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (ph_q) begin
                        state_d = S_STB_LO;
                        ph_d    = 1'b0;
                        stb_d   = 1'b0;
                        oe_d    = 1'b1;
                        txn_d   = 2'd0;
                        byte_d  = '0;
                        bit_d   = '0;
                        snap    = 1'b1;
                    end else begin
                        ph_d = 1'b1;
                    end
                end
            end
            S_STB_LO: begin
                if (tick) begin
                    state_d = S_SHIFT_OUT;
                    clk_d   = 1'b0;
                    dout_d  = tx_byte[bit_q];
                    ph_d    = 1'b1;
                end
            end
            S_SHIFT_OUT: begin
                if (tick) begin
                    if (ph_q) begin
                        clk_d = 1'b1;
                        ph_d  = 1'b0;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 5'd1;
                            if (txn_q == 2'd3) begin
                                state_d = S_RD_WAIT;
                                oe_d    = 1'b0;
                                byte_d  = '0;
                            end
                        end
                    end else if (byte_q == n_bytes) begin
                        state_d = S_STB_HI;
                        stb_d   = 1'b1;
                    end else begin
                        clk_d  = 1'b0;
                        dout_d = tx_byte[bit_q];
                        ph_d   = 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (tick) begin
                    state_d = S_SHIFT_IN;
                    clk_d   = 1'b0;
                    ph_d    = 1'b1;
                end
            end
            S_SHIFT_IN: begin
                if (tick) begin
                    if (ph_q) begin
                        clk_d  = 1'b1;
                        ph_d   = 1'b0;
                        bit_d  = bit_q + 3'd1;
                        sample = 1'b1;
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 5'd1;
                            if (byte_q == 5'd3) begin
                                rd_last = 1'b1;
                            end
                        end
                    end else if (byte_q == 5'd4) begin
                        state_d = S_STB_HI;
                        stb_d   = 1'b1;
                    end else begin
                        clk_d = 1'b0;
                        ph_d  = 1'b1;
                    end
                end
            end
            S_STB_HI: begin
                if (tick) begin
                    if (ph_q) begin
                        ph_d = 1'b0;
                        oe_d = 1'b1;
                        if (txn_q == 2'd3) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_STB_LO;
                            stb_d   = 1'b0;
                            txn_d   = txn_q + 2'd1;
                            byte_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        ph_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ph_q      <= 1'b0;
            bit_q     <= '0;
            byte_q    <= '0;
            txn_q     <= '0;
            stb_q     <= 1'b1;
            clk_q     <= 1'b1;
            dout_q    <= 1'b1;
            oe_q      <= 1'b0;
            key_acc_q <= '0;
            key_q     <= '0;
            rd_done_q <= 1'b0;
            kv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            txn_q     <= txn_d;
            stb_q     <= stb_d;
            clk_q     <= clk_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            if (snap) begin
                seg_s_q <= seg_data;
                led_s_q <= led;
                bri_s_q <= brightness;
                don_s_q <= display_on;
            end
            // Only bits 0 and 4 of each read byte carry keys; index = {bit[2], byte}
            if (sample && (bit_q[1:0] == 2'b00)) begin
                key_acc_q[{bit_q[2], byte_q[1:0]}] <= tm_dio_in;
            end
            rd_done_q <= rd_last;
            kv_q      <= rd_done_q;
            if (rd_done_q) begin
                key_q <= key_acc_q;
            end
        end
    end

    assign key        = w_key'(key_q);
    assign key_valid  = kv_q;
    assign busy       = ~stb_q;
    assign tm_stb     = stb_q;
    assign tm_clk     = clk_q;
    assign tm_dio_out = dout_q;
    assign tm_dio_oe  = oe_q;

endmodule

// File: tb/tb_tm1638_ctrl.sv
// Directed bench for tm1638_ctrl: pin-level TM1638 model decodes written bytes and
// returns key bytes; byte and key scoreboards are filled when each frame is set up.
`timescale 1ns/1ps
module tb_tm1638_ctrl;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [63:0] seg_data   = '0;
    logic [7:0]  led        = '0;
    logic [2:0]  brightness = '0;
    logic        display_on = 1'b0;
    logic [7:0]  key;
    logic        key_valid;
    logic        busy;
    logic        tm_stb;
    logic        tm_clk;
    logic        tm_dio_out;
    logic        tm_dio_oe;
    logic        tm_dio_in;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_key_q[$];

    logic [31:0] bfm_rd     = '0;
    logic        bfm_drive  = 1'b0;
    logic        bfm_dio    = 1'b1;
    logic        prev_clk   = 1'b1;
    logic        prev_stb   = 1'b1;
    logic        prev_dio   = 1'b1;
    logic        prev_rst   = 1'b1;
    logic        prev_kv    = 1'b0;
    logic [7:0]  shreg      = '0;
    logic [7:0]  first_byte = '0;
    int          bitn       = 0;
    int          nbytes     = 0;
    int          rd_idx     = 0;
    int          partials   = 0;
    longint      cyc        = 0;
    longint      t_turn     = 0;

    assign tm_dio_in = bfm_drive ? bfm_dio : 1'b1;

    tm1638_ctrl #(
        .clk_mhz (27),
        .sclk_khz(500),
        .w_digit (8),
        .w_led   (8),
        .w_key   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_data  (seg_data),
        .led       (led),
        .brightness(brightness),
        .display_on(display_on),
        .key       (key),
        .key_valid (key_valid),
        .busy      (busy),
        .tm_stb    (tm_stb),
        .tm_clk    (tm_clk),
        .tm_dio_out(tm_dio_out),
        .tm_dio_oe (tm_dio_oe),
        .tm_dio_in (tm_dio_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic log_byte(input logic [7:0] b);
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL byte_unexpected: observed %0h expected none", b);
        end
        if (exp_q.size() > 0) begin
            check($sformatf("byte%0d", nbytes), 64'(b), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic set_frame(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b,
                             input logic d, input logic [31:0] rd, input logic [7:0] k);
        seg_data   = s;
        led        = l;
        brightness = b;
        display_on = d;
        bfm_rd     = rd;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(s[8*i +: 8]);
            exp_q.push_back({7'b0, l[i]});
        end
        exp_q.push_back({4'b1000, d, b});
        exp_q.push_back(8'h42);
        exp_key_q.push_back(k);
    endtask

    task automatic wait_kv(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_valid !== 1'b1 && n < 15000);
        checks++;
        assert (n < 15000) else begin
            errors++;
            $error("FAIL %s: observed no key_valid in %0d cycles, expected a pulse", tag, n);
        end
    endtask

    // Pin-level TM1638 model, evaluated away from the DUT clock edge
    always @(negedge clk) begin
        if (bfm_drive) check("dio_contention", 64'(tm_dio_oe), 64'h0);
        if (tm_dio_out !== prev_dio && !rst && !prev_rst) check("dio_change_clk_low", 64'(tm_clk), 64'h0);
        if (!prev_stb && tm_stb) begin
            if (bitn != 0) partials++;
            bitn      = 0;
            bfm_drive = 1'b0;
        end
        if (prev_stb && !tm_stb) begin
            bitn       = 0;
            nbytes     = 0;
            first_byte = '0;
        end
        if (!tm_stb && !prev_clk && tm_clk) begin
            if (bfm_drive) begin
                rd_idx++;
            end else begin
                shreg = {tm_dio_out, shreg[7:1]};
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    if (nbytes == 0) first_byte = shreg;
                    nbytes++;
                    log_byte(shreg);
                    if (nbytes == 1 && shreg == 8'h42) begin
                        bfm_drive = 1'b1;
                        rd_idx    = 0;
                        t_turn    = cyc;
                        check("oe_off_at_turn", 64'(tm_dio_oe), 64'h0);
                    end
                end
            end
        end
        if (!tm_stb && prev_clk && !tm_clk && bfm_drive) begin
            if (rd_idx == 0) check("turnaround_cycles", 64'(cyc - t_turn), 64'd54);
            if (rd_idx < 32) bfm_dio = bfm_rd[rd_idx];
        end
        if (prev_kv) check("key_valid_one_cycle", 64'(key_valid), 64'h0);
        if (key_valid === 1'b1) begin
            checks++;
            assert (exp_key_q.size() > 0) else begin
                errors++;
                $error("FAIL key_unexpected: observed %0h expected none", key);
            end
            if (exp_key_q.size() > 0) check("key", 64'(key), 64'(exp_key_q.pop_front()));
        end
        prev_clk = tm_clk;
        prev_stb = tm_stb;
        prev_dio = tm_dio_out;
        prev_rst = rst;
        prev_kv  = key_valid;
    end

    initial begin
        int k;
        int n;

        // Frame A: keys 0x01,0x10,0x00,0x11 -> 8'hA9
        set_frame(64'h0123_4567_89AB_CDEF, 8'h81, 3'd5, 1'b1, 32'h1100_1001, 8'hA9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stb", 64'(tm_stb), 64'h1);
        check("rst_clk", 64'(tm_clk), 64'h1);
        check("rst_dio_out", 64'(tm_dio_out), 64'h1);
        check("rst_oe", 64'(tm_dio_oe), 64'h0);
        check("rst_key", 64'(key), 64'h0);
        check("rst_key_valid", 64'(key_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;

        k = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (tm_stb === 1'b0) begin
                k = i;
                break;
            end
        end
        check("first_stb_fall_cycles", 64'(k), 64'd54);
        check("busy_in_frame", 64'(busy), 64'h1);
        wait_kv("frameA");

        // Frame B: display off, all-zero key bytes
        set_frame(64'hFEDC_BA98_7654_3210, 8'h3C, 3'd5, 1'b0, 32'h0000_0000, 8'h00);
        wait_kv("frameB");

        // Frame C: keys 0x11,0x00,0x01,0x10 -> 8'h95
        set_frame(64'h5A5A_A5A5_0F0F_F0F0, 8'h55, 3'd7, 1'b1, 32'h1001_0011, 8'h95);
        wait_kv("frameC");
        repeat (5) @(negedge clk);
        check("key_hold", 64'(key), 64'h95);

        // Frame D is cut by reset in the 5th T2 data byte
        set_frame(64'h1122_3344_5566_7788, 8'hF0, 3'd2, 1'b1, 32'hFFFF_FFFF, 8'hFF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(first_byte == 8'hC0 && nbytes == 5 && bitn == 3 && tm_stb === 1'b0) && n < 15000);
        checks++;
        assert (n < 15000) else begin
            errors++;
            $error("FAIL reach_t2_byte5: observed timeout after %0d cycles, expected T2 byte 5", n);
        end
        rst = 1'b1;
        exp_q.delete();
        exp_key_q.delete();
        @(negedge clk);
        check("midrst_stb", 64'(tm_stb), 64'h1);
        check("midrst_clk", 64'(tm_clk), 64'h1);
        check("midrst_oe", 64'(tm_dio_oe), 64'h0);
        check("midrst_key", 64'(key), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        check("partial_byte_dropped", 64'(partials), 64'd1);

        // Frame E after release: keys 0x00,0x01,0x10,0x00 -> 8'h42
        set_frame(64'h0011_2233_4455_6677, 8'h0F, 3'd3, 1'b1, 32'h0010_0100, 8'h42);
        rst = 1'b0;
        wait_kv("frameE");
        @(negedge clk);
        check("byte_queue_drained", 64'(exp_q.size()), 64'd0);
        check("key_queue_drained", 64'(exp_key_q.size()), 64'd0);
        check("key_final", 64'(key), 64'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
